pulse_capture: RTL

- Timing measurement block, the receive side of the delay/pulse generator.
- Each rising edge of t0 arms a measurement. The block then times two intervals on input pin: t0 to pin rising edge (delay), and pin rising edge to pin falling edge (width).
- Results are presented on a valid/ready interface for the host/CSR bridge.
- Used for loopback self-test of generator channels and for timing external detector pulses against t0.

---
 rtl/pulse_capture_if.sv | 14 +
 rtl/pulse_capture.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pulse_capture_if.sv
// Result channel of pulse_capture: measured delay/width/status with a valid/ready handshake.
`timescale 1ns/1ps
interface pulse_capture_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] delay;
  logic [WIDTH-1:0] width;
  logic [1:0]       status;
  logic             valid;
  logic             ready;

  modport master (output delay, output width, output status, output valid, input ready);
  modport slave  (input delay, input width, input status, input valid, output ready);
endinterface

// File: rtl/pulse_capture.sv
// Times t0-edge to pin-rise (delay) and pin-rise to pin-fall (width); result is registered,
// valid rises on the fall/timeout/overflow edge and is held until valid&ready.
`timescale 1ns/1ps
module pulse_capture #(
  parameter int WIDTH  = 32,
  parameter int OFFSET = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               t0,
  input  logic               pin,
  input  logic [WIDTH-1:0]   timeout,
  pulse_capture_if.master    res,
  output logic               busy,
  output logic [7:0]         missed
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_RISE = 2'd1;
  localparam logic [1:0] WAIT_FALL = 2'd2;
  localparam logic [1:0] HOLD      = 2'd3;

  localparam logic [WIDTH-1:0] OFS  = WIDTH'(OFFSET);
  localparam logic [WIDTH-1:0] ALL1 = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] delay_q, delay_d;
  logic [WIDTH-1:0] width_q, width_d;
  logic [1:0]       status_q, status_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [7:0]       missed_q, missed_d;
  logic             t0_dly_q, t0_dly_d;
  logic             pin_dly_q, pin_dly_d;

  logic             t0_edge, rise, fall;
  logic             tmo_hit, ovf_hit;
  logic [WIDTH-1:0] cnt_inc, raw_adj, tmo_adj;
  logic [7:0]       missed_inc;

  always_comb begin
    t0_edge    = t0 & ~t0_dly_q;
    rise       = pin & ~pin_dly_q;
    fall       = ~pin & pin_dly_q;
    cnt_inc    = cnt_q + ONE;
    tmo_hit    = (timeout != '0) && (cnt_inc == timeout);
    ovf_hit    = (timeout == '0) && (cnt_inc == ALL1);
    raw_adj    = (cnt_inc > OFS) ? (cnt_inc - OFS) : '0;
    tmo_adj    = (timeout > OFS) ? (timeout - OFS) : '0;
    missed_inc = (missed_q == 8'hFF) ? missed_q : (missed_q + 8'd1);

    state_d   = state_q;
    cnt_d     = cnt_q;
    delay_d   = delay_q;
    width_d   = width_q;
    status_d  = status_q;
    valid_d   = valid_q;
    missed_d  = missed_q;
    t0_dly_d  = t0;
    pin_dly_d = pin;

    case (state_q)
      IDLE: begin
        if (t0_edge) begin
          cnt_d   = '0;
          state_d = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (t0_edge) begin
          cnt_d    = '0;
          missed_d = missed_inc;
        end else if (rise) begin
          delay_d = raw_adj;
          cnt_d   = '0;
          state_d = WAIT_FALL;
        end else if (tmo_hit) begin
          delay_d  = tmo_adj;
          width_d  = '0;
          status_d = 2'b01;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end else if (ovf_hit) begin
          delay_d  = ALL1;
          width_d  = '0;
          status_d = 2'b11;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_FALL: begin
        if (t0_edge) begin
          cnt_d    = '0;
          missed_d = missed_inc;
          state_d  = WAIT_RISE;
        end else if (fall) begin
          width_d  = cnt_inc;
          status_d = 2'b00;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end else if (tmo_hit) begin
          width_d  = timeout;
          status_d = 2'b10;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end else if (ovf_hit) begin
          width_d  = ALL1;
          status_d = 2'b11;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        // A t0 edge coinciding with the handshake starts the next measurement without loss.
        if (valid_q && res.ready) begin
          valid_d = 1'b0;
          if (t0_edge) begin
            cnt_d   = '0;
            state_d = WAIT_RISE;
          end else begin
            state_d = IDLE;
          end
        end else if (t0_edge) begin
          missed_d = missed_inc;
        end
      end
    endcase

    busy_d = (state_d == WAIT_RISE) || (state_d == WAIT_FALL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      delay_q   <= '0;
      width_q   <= '0;
      status_q  <= 2'b00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      missed_q  <= 8'd0;
      t0_dly_q  <= 1'b0;
      pin_dly_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      delay_q   <= delay_d;
      width_q   <= width_d;
      status_q  <= status_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      missed_q  <= missed_d;
      t0_dly_q  <= t0_dly_d;
      pin_dly_q <= pin_dly_d;
    end
  end

  assign res.delay  = delay_q;
  assign res.width  = width_q;
  assign res.status = status_q;
  assign res.valid  = valid_q;
  assign busy       = busy_q;
  assign missed     = missed_q;

endmodule
